present80_key_schedule: RTL and testbench

//   PRESENT-80 key schedule. Holds the 80-bit key register and presents the 64-bit round key
//   K[79:16] for the current round. On request from the cipher FSM, it advances the key

---
 rtl/present80_key_schedule.sv | 83 ++++++++
 tb/tb_present80_key_schedule.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/present80_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module   : present80_key_schedule
//  Purpose  : PRESENT-80 key schedule. Holds the 80-bit key register K and
//             presents the current 64-bit round key K[79:16]. The cipher
//             controller loads the user key, then requests one-round
//             advances, supplying the round index for each advance.
//  Ports    :
//    clk            in   1   system clock, all state on rising edge
//    rst_n          in   1   asynchronous active-low reset (clears K)
//    load_key       in   1   load key_input into K (has priority)
//    update_key     in   1   advance K by one round
//    round_counter  in   5   round index XORed into K[19:15] on update
//    key_input      in   80  user key, bit 79 = MSB
//    round_key      out  64  current round key = K[79:16]
//  Revision : 1.0  initial release
// ============================================================================
module present80_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_key,
    input  logic        update_key,
    input  logic [4:0]  round_counter,
    input  logic [79:0] key_input,
    output logic [63:0] round_key
);

    logic [79:0] r_key;
    logic [79:0] w_rot;
    logic [79:0] w_next;
    logic [3:0]  w_sbox_out;

    // Rotate left by 61 (equivalently right by 19).
    assign w_rot = {r_key[18:0], r_key[79:19]};

    // PRESENT 4-bit S-box applied to the top nibble of the rotated key.
    always_comb begin
        w_sbox_out = 4'h0;
        case (w_rot[79:76])
            4'h0: w_sbox_out = 4'hC;
            4'h1: w_sbox_out = 4'h5;
            4'h2: w_sbox_out = 4'h6;
            4'h3: w_sbox_out = 4'hB;
            4'h4: w_sbox_out = 4'h9;
            4'h5: w_sbox_out = 4'h0;
            4'h6: w_sbox_out = 4'hA;
            4'h7: w_sbox_out = 4'hD;
            4'h8: w_sbox_out = 4'h3;
            4'h9: w_sbox_out = 4'hE;
            4'hA: w_sbox_out = 4'hF;
            4'hB: w_sbox_out = 4'h8;
            4'hC: w_sbox_out = 4'h4;
            4'hD: w_sbox_out = 4'h7;
            4'hE: w_sbox_out = 4'h1;
            4'hF: w_sbox_out = 4'h2;
            default: w_sbox_out = 4'h0;
        endcase
    end

    // Next-round key: S-box on the top nibble, round index folded into
    // bits 19:15. The two fields never overlap, so ordering is irrelevant.
    always_comb begin
        w_next          = w_rot;
        w_next[79:76]   = w_sbox_out;
        w_next[19:15]   = w_rot[19:15] ^ round_counter;
    end

    // Load beats update; with neither asserted the key holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key <= 80'h0;
        end else if (load_key) begin
            r_key <= key_input;
        end else if (update_key) begin
            r_key <= w_next;
        end
    end

    // Round key is a direct slice of the register, no output stage.
    assign round_key = r_key[79:16];

endmodule
`default_nettype wire

// File: tb/tb_present80_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module   : tb_present80_key_schedule
//  Purpose  : Self-checking bench for present80_key_schedule. Known-answer
//             vector table, hand-written reset/async-reset sequences, the
//             full 31-round all-zero-key schedule, and randomized traffic
//             compared against a behavioural model of the key schedule.
//  Revision : 1.0  initial release
// ============================================================================
module tb_present80_key_schedule;

    logic        clk;
    logic        rst_n;
    logic        load_key;
    logic        update_key;
    logic [4:0]  round_counter;
    logic [79:0] key_input;
    logic [63:0] round_key;

    int checks = 0;
    int errors = 0;

    // Reference model state: the full 80-bit key as the algorithm defines it.
    logic [79:0] m_key;

    logic [3:0] c_sbox [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    typedef struct {
        string       name;
        logic        ld;
        logic        up;
        logic [4:0]  rc;
        logic [79:0] key;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

    present80_key_schedule u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_key      (load_key),
        .update_key    (update_key),
        .round_counter (round_counter),
        .key_input     (key_input),
        .round_key     (round_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One round of the PRESENT-80 key schedule, written from the algorithm:
    // 80-bit rotate via shifts, S-box table lookup, round index XOR.
    function automatic logic [79:0] model_next(input logic [79:0] k, input int i);
        logic [79:0] t;
        logic [79:0] rc_field;
        t        = (k << 61) | (k >> 19);
        t[79:76] = c_sbox[t[79:76]];
        rc_field = 80'(i % 32);
        t        = t ^ (rc_field << 15);
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %016h expected %016h", name, act, exp);
        end
    endtask

    // Present inputs, take one rising edge, sample 1 ns later.
    task automatic step(input logic ld, input logic up, input logic [4:0] rc,
                        input logic [79:0] k);
        load_key      = ld;
        update_key    = up;
        round_counter = rc;
        key_input     = k;
        @(posedge clk);
        #1;
        load_key   = 1'b0;
        update_key = 1'b0;
        if (ld)      m_key = k;
        else if (up) m_key = model_next(m_key, int'(rc));
    endtask

    function automatic logic [79:0] rand80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    initial begin
        rst_n         = 1'b0;
        load_key      = 1'b0;
        update_key    = 1'b0;
        round_counter = 5'd0;
        key_input     = 80'h0;
        m_key         = 80'h0;

        // Reset held across edges, then released with no activity.
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", round_key, 64'h0);
        #2 rst_n = 1'b1;
        step(1'b0, 1'b0, 5'd7, 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
        step(1'b0, 1'b0, 5'd3, 80'h1234_5678_9ABC_DEF0_1234);
        check("reset_release_hold", round_key, 64'h0);

        // Known-answer table, applied in order.
        vecs.push_back('{"load_zero",   1'b1, 1'b0, 5'd0,  80'h0, 64'h0000000000000000});
        vecs.push_back('{"zero_up1",    1'b0, 1'b1, 5'd1,  80'h0, 64'hC000000000000000});
        vecs.push_back('{"zero_up2",    1'b0, 1'b1, 5'd2,  80'h0, 64'h5000180000000001});
        vecs.push_back('{"load_ones",   1'b1, 1'b0, 5'd0,  80'hFFFF_FFFF_FFFF_FFFF_FFFF,
                         64'hFFFFFFFFFFFFFFFF});
        vecs.push_back('{"ones_up1",    1'b0, 1'b1, 5'd1,  80'h0, 64'h2FFFFFFFFFFFFFFF});
        vecs.push_back('{"load_beats_up", 1'b1, 1'b1, 5'd9, 80'h0123_4567_89AB_CDEF_0123,
                         64'h0123456789ABCDEF});
        vecs.push_back('{"idle1",       1'b0, 1'b0, 5'd4,  80'hFFFF_0000_FFFF_0000_FFFF,
                         64'h0123456789ABCDEF});
        vecs.push_back('{"idle2",       1'b0, 1'b0, 5'd31, 80'h0,  64'h0123456789ABCDEF});
        vecs.push_back('{"reload_zero", 1'b1, 1'b1, 5'd31, 80'h0,  64'h0000000000000000});
        vecs.push_back('{"zero_up_i0",  1'b0, 1'b1, 5'd0,  80'h0,  64'hC000000000000000});

        for (int n = 0; n < vecs.size(); n++) begin
            step(vecs[n].ld, vecs[n].up, vecs[n].rc, vecs[n].key);
            check(vecs[n].name, round_key, vecs[n].exp);
        end

        // After ones_up1 the hidden low bits matter: one more round exposes them.
        step(1'b1, 1'b0, 5'd0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
        step(1'b0, 1'b1, 5'd1, 80'h0);
        step(1'b0, 1'b1, 5'd2, 80'h0);
        check("ones_up2_model", round_key, m_key[79:16]);

        // Full schedule of the all-zero key, consecutive updates.
        step(1'b1, 1'b0, 5'd0, 80'h0);
        for (int i = 1; i <= 31; i++) begin
            step(1'b0, 1'b1, 5'(i), 80'h0);
            if (i % 8 == 0) check($sformatf("zero_sched_r%0d", i + 1), round_key, m_key[79:16]);
        end
        check("zero_key_K32", round_key, 64'h6DAB31744F41D700);

        // Asynchronous reset mid-sequence, asserted between edges.
        step(1'b1, 1'b0, 5'd0, 80'hDEAD_BEEF_CAFE_F00D_1357);
        step(1'b0, 1'b1, 5'd1, 80'h0);
        step(1'b0, 1'b1, 5'd2, 80'h0);
        check("pre_async_rst", round_key, m_key[79:16]);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_immediate", round_key, 64'h0);
        m_key = 80'h0;
        step(1'b1, 1'b1, 5'd5, 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
        m_key = 80'h0;
        check("rst_beats_load", round_key, 64'h0);
        #2 rst_n = 1'b1;
        step(1'b0, 1'b0, 5'd0, 80'h0);
        check("post_rst_idle", round_key, 64'h0);

        // Randomized traffic against the behavioural model.
        for (int n = 0; n < 400; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            step(op == 0 || op == 9, op <= 6, 5'($urandom), rand80());
            if (n % 20 == 19) check($sformatf("rand_%0d", n), round_key, m_key[79:16]);
            else if (round_key !== m_key[79:16]) check($sformatf("rand_%0d", n), round_key, m_key[79:16]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
